// File: rtl/uart_tx_buf.sv
// Byte FIFO and frame scheduler feeding a UART transmitter: buffers host writes and
// issues one byte per frame only while the transmitter is idle, with an optional gap.
module uart_tx_buf #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              flush,
    input  logic              tx_en,
    output logic              wr_full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DATA_W-1:0] tx_din,
    output logic              tx_din_vld,
    input  logic              tx_busy,
    output logic              frame_done
);

    // Handshake: tx_din_vld is a one-cycle load strobe issued only when tx_busy was low
    // at the read; the transmitter answers by holding tx_busy high until its stop bit ends.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [GW-1:0]     gap_cnt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_next;
    logic              wr_accept;
    logic              read_fire;

    // Full is the registered flag, so a write beside a read still sees pre-read fullness.
    assign wr_accept  = wr_en && !wr_full && !flush;
    assign level_next = level + (AW+1)'(wr_accept) - (AW+1)'(read_fire);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            wr_full  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            level   <= level_next;
            empty   <= (level_next == '0);
            wr_full <= (level_next == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_din <= '0;
        end else if (read_fire) begin
            tx_din <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (tx_en && !empty && !tx_busy) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: state_next = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    state_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        read_fire  = 1'b0;
        tx_din_vld = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: read_fire  = tx_en && !empty && !tx_busy;
            S_LOAD: tx_din_vld = 1'b1;
            S_WAIT: frame_done = !tx_busy;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: transmitter busy model, expected-byte scoreboard with monitor,
// directed scenarios on a GAP_CYC=0 instance plus a GAP_CYC=4 instance for gap timing.
module tb_uart_tx_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       flush = 1'b0;
    logic       tx_en = 1'b0;
    logic       wr_full, empty, overflow, tx_din_vld, frame_done;
    logic [4:0] level;
    logic [7:0] tx_din;
    logic       tx_busy;

    logic [7:0] wr_data_g = '0;
    logic       wr_en_g = 1'b0;
    logic       wr_full_g, empty_g, overflow_g, tx_din_vld_g, frame_done_g;
    logic [4:0] level_g;
    logic [7:0] tx_din_g;
    logic       tx_busy_g;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int fd_cnt = 0;
    int busy_len = 5;
    int busy_cnt = 0;
    int busy_cnt_g = 0;
    logic       prev_vld = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_buf #(.DATA_W(8), .DEPTH(16), .AW(4), .GAP_CYC(0)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
        .tx_en(tx_en), .wr_full(wr_full), .empty(empty), .level(level),
        .overflow(overflow), .tx_din(tx_din), .tx_din_vld(tx_din_vld),
        .tx_busy(tx_busy), .frame_done(frame_done)
    );

    uart_tx_buf #(.DATA_W(8), .DEPTH(16), .AW(4), .GAP_CYC(4)) dut_g (
        .clk(clk), .rst(rst), .wr_data(wr_data_g), .wr_en(wr_en_g), .flush(1'b0),
        .tx_en(1'b1), .wr_full(wr_full_g), .empty(empty_g), .level(level_g),
        .overflow(overflow_g), .tx_din(tx_din_g), .tx_din_vld(tx_din_vld_g),
        .tx_busy(tx_busy_g), .frame_done(frame_done_g)
    );

    // Clock and transmitter models: busy from the cycle after a load for busy_len cycles.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_din_vld) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (tx_din_vld_g) busy_cnt_g <= 10;
        else if (busy_cnt_g != 0) busy_cnt_g <= busy_cnt_g - 1;
    end
    assign tx_busy   = (busy_cnt != 0);
    assign tx_busy_g = (busy_cnt_g != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every load pulse is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_din_vld) begin
                vld_cnt++;
                check("vld_while_busy", tx_busy, 0);
                check("vld_single_cycle", prev_vld, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_vld", tx_din_vld, 0);
                end else begin
                    check("tx_din_order", tx_din, exp_q.pop_front());
                end
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_busy_low", tx_busy, 0);
            end
        end
        prev_vld = tx_din_vld;
    end

    task automatic write_byte(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !tx_busy && empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_vld(input int target, input int budget);
        int n = 0;
        while (vld_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("vld_timeout", (n < budget), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, wr_full, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_tx_din"}, tx_din, 0);
        check({tag, "_vld"}, tx_din_vld, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int v0, f0, n, t_fall, t2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        tx_en = 1'b1;

        // Single byte latency: write at N, load pulse at N+2, one cycle wide.
        busy_len = 5;
        write_byte(8'h55, 1'b1);
        check("t1_vld_n1", tx_din_vld, 0);
        @(negedge clk);
        check("t1_vld_n2", tx_din_vld, 1);
        check("t1_din_n2", tx_din, 8'h55);
        @(negedge clk);
        check("t1_vld_n3", tx_din_vld, 0);
        wait_drain(100);

        // Three back-to-back bytes, long frames.
        busy_len = 100;
        v0 = vld_cnt;
        f0 = fd_cnt;
        write_byte(8'h01, 1'b1);
        write_byte(8'h02, 1'b1);
        write_byte(8'h03, 1'b1);
        wait_drain(1000);
        check("t2_pulses", vld_cnt - v0, 3);
        check("t2_frame_done", fd_cnt - f0, 3);

        // Fill with scheduling disabled; the 17th write is dropped.
        tx_en = 1'b0;
        busy_len = 3;
        for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i), (i < 16));
        check("t3_level", level, 16);
        check("t3_full", wr_full, 1);
        check("t3_overflow", overflow, 1);
        check("t3_empty", empty, 0);
        v0 = vld_cnt;
        tx_en = 1'b1;
        wait_drain(500);
        check("t3_drained", vld_cnt - v0, 16);
        check("t3_overflow_sticky", overflow, 1);

        // Flush with one frame in flight and five queued; flush beats a same-cycle write.
        busy_len = 30;
        v0 = vld_cnt;
        for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i), 1'b1);
        wait_vld(v0 + 1, 50);
        repeat (4) @(negedge clk);
        check("t4_level_before", level, 5);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        exp_q.delete();
        f0 = fd_cnt;
        v0 = vld_cnt;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        check("t4_level", level, 0);
        check("t4_overflow", overflow, 0);
        check("t4_empty", empty, 1);
        repeat (40) @(negedge clk);
        check("t4_inflight_done", fd_cnt - f0, 1);
        check("t4_no_more_vld", vld_cnt - v0, 0);

        // Reset during WAIT with three queued.
        v0 = vld_cnt;
        for (int i = 0; i < 4; i++) write_byte(8'hB0 + 8'(i), 1'b1);
        wait_vld(v0 + 1, 50);
        repeat (3) @(negedge clk);
        check("t6_level_before", level, 3);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("t6");
        v0 = vld_cnt;
        repeat (60) @(negedge clk);
        check("t6_no_vld", vld_cnt - v0, 0);
        write_byte(8'hC3, 1'b1);
        wait_drain(200);
        check("t6_new_write", vld_cnt - v0, 1);

        // Gap instance: second load exactly 6 cycles after busy falls.
        wr_en_g = 1'b1;
        wr_data_g = 8'h5A;
        @(negedge clk);
        wr_data_g = 8'hA5;
        @(negedge clk);
        wr_en_g = 1'b0;
        n = 0;
        while (!tx_din_vld_g && n < 50) begin @(negedge clk); n++; end
        check("t5_first_vld", tx_din_vld_g, 1);
        check("t5_first_din", tx_din_g, 8'h5A);
        n = 0;
        while (!tx_busy_g && n < 50) begin @(negedge clk); n++; end
        while (tx_busy_g && n < 100) begin @(negedge clk); n++; end
        t_fall = cyc;
        check("t5_frame_done", frame_done_g, 1);
        n = 0;
        while (!tx_din_vld_g && n < 50) begin @(negedge clk); n++; end
        t2 = cyc;
        check("t5_second_vld", tx_din_vld_g, 1);
        check("t5_gap_cycles", t2 - t_fall, 6);
        check("t5_second_din", tx_din_g, 8'hA5);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
